// File: rtl/stepper_move_queue_if.sv
// Move-source / stepper-driver bundle for stepper_move_queue: move push handshake,
// queue status and the shared step/dir bus with per-motor enables.
interface stepper_move_queue_if #(
  parameter int NUM_MOTORS  = 6,
  parameter int QUEUE_DEPTH = 16
) ();
  localparam int FACE_W = $clog2(NUM_MOTORS);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;

  logic [FACE_W+1:0]     move_in;
  logic                  move_valid;
  logic                  move_ready;
  logic                  flush;
  logic                  busy;
  logic [CNT_W-1:0]      queue_count;
  logic                  moves_done;
  logic                  error;
  logic                  dir_pin;
  logic                  step_pin;
  logic [NUM_MOTORS-1:0] en_pins;

  modport master (
    output move_in, move_valid, flush,
    input  move_ready, busy, queue_count, moves_done, error, dir_pin, step_pin, en_pins
  );

  modport slave (
    input  move_in, move_valid, flush,
    output move_ready, busy, queue_count, moves_done, error, dir_pin, step_pin, en_pins
  );
endinterface

// File: rtl/stepper_move_queue.sv
// Queued face-move sequencer: buffers moves in a FIFO and plays each one out as an
// enable-settle, step pulse train, settle-disable sequence on a shared step/dir bus.
module stepper_move_queue #(
  parameter int NUM_MOTORS        = 6,
  parameter int STEPS_PER_QUARTER = 50,
  parameter int STEP_HALF_PERIOD  = 12500,
  parameter int SETTLE_CYCLES     = 25000,
  parameter int QUEUE_DEPTH       = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  stepper_move_queue_if.slave  bus
);

  localparam int FACE_W  = $clog2(NUM_MOTORS);
  localparam int MOVE_W  = FACE_W + 2;
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STEP_W  = $clog2(2 * STEPS_PER_QUARTER + 1);
  localparam int DLY_MAX = (SETTLE_CYCLES > STEP_HALF_PERIOD) ? SETTLE_CYCLES : STEP_HALF_PERIOD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  localparam logic [CNT_W-1:0]      FULL_CNT    = CNT_W'(QUEUE_DEPTH);
  localparam logic [DLY_W-1:0]      SETTLE_LOAD = DLY_W'(SETTLE_CYCLES - 1);
  localparam logic [DLY_W-1:0]      HALF_LOAD   = DLY_W'(STEP_HALF_PERIOD - 1);
  localparam logic [NUM_MOTORS-1:0] ONE_HOT     = NUM_MOTORS'(1);
  localparam logic [NUM_MOTORS-1:0] ALL_OFF     = '1;

  typedef enum logic [2:0] {
    IDLE, LOAD, ENABLE, STEP_HI, STEP_LO, DISABLE, DONE
  } state_t;

  function automatic logic [STEP_W-1:0] steps_for(input logic [1:0] turn);
    return (turn == 2'b11) ? STEP_W'(2 * STEPS_PER_QUARTER) : STEP_W'(STEPS_PER_QUARTER);
  endfunction

  state_t                state;
  logic [MOVE_W-1:0]     mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [MOVE_W-1:0]     move_q;
  logic [FACE_W-1:0]     face_q;
  logic [1:0]            turn_q;
  logic [STEP_W-1:0]     steps;
  logic [DLY_W-1:0]      dly;
  logic                  step_pin;
  logic                  dir_pin;
  logic [NUM_MOTORS-1:0] en_pins;
  logic                  moves_done;
  logic                  error;
  logic                  push_ok;
  logic                  pop;

  // A flush in the same cycle as a push or pop wins: nothing enters or leaves.
  assign push_ok = bus.move_valid && (count != FULL_CNT) && !bus.flush;
  assign pop     = (state == IDLE) && (count != '0) && !bus.flush;
  assign face_q  = move_q[FACE_W-1:0];
  assign turn_q  = move_q[MOVE_W-1:FACE_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= bus.move_in;
  end

  always_ff @(posedge clock) begin
    if (pop) move_q <= mem[rd_ptr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      steps      <= '0;
      dly        <= '0;
      step_pin   <= 1'b0;
      dir_pin    <= 1'b0;
      en_pins    <= ALL_OFF;
      moves_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      moves_done <= 1'b0;
      error      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) state <= LOAD;
        end
        LOAD: begin
          if (int'(face_q) >= NUM_MOTORS) begin
            error <= 1'b1;
            state <= IDLE;
          end else if (turn_q == 2'b00) begin
            state <= IDLE;
          end else begin
            en_pins <= ~(ONE_HOT << face_q);
            dir_pin <= (turn_q != 2'b10);
            steps   <= steps_for(turn_q);
            dly     <= SETTLE_LOAD;
            state   <= ENABLE;
          end
        end
        ENABLE: begin
          if (dly == '0) begin
            step_pin <= 1'b1;
            dly      <= HALF_LOAD;
            state    <= STEP_HI;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        STEP_HI: begin
          if (dly == '0) begin
            step_pin <= 1'b0;
            dly      <= HALF_LOAD;
            state    <= STEP_LO;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        STEP_LO: begin
          if (dly == '0) begin
            steps <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) begin
              dly   <= SETTLE_LOAD;
              state <= DISABLE;
            end else begin
              step_pin <= 1'b1;
              dly      <= HALF_LOAD;
              state    <= STEP_HI;
            end
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        DISABLE: begin
          if (dly == '0) begin
            en_pins <= ALL_OFF;
            state   <= DONE;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        DONE: begin
          moves_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.move_ready  = (count != FULL_CNT);
  assign bus.busy        = (state != IDLE) || (count != '0);
  assign bus.queue_count = count;
  assign bus.moves_done  = moves_done;
  assign bus.error       = error;
  assign bus.dir_pin     = dir_pin;
  assign bus.step_pin    = step_pin;
  assign bus.en_pins     = en_pins;

endmodule

// File: tb/tb_stepper_move_queue.sv
// Bench for stepper_move_queue: directed scenarios plus random move bursts, with each
// completed move's waveform summarised and compared against a move-level model.
module tb_stepper_move_queue;
  localparam int NM     = 6;
  localparam int SPQ    = 4;
  localparam int HALF   = 3;
  localparam int SETTLE = 5;
  localparam int DEPTH  = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  stepper_move_queue_if #(.NUM_MOTORS(NM), .QUEUE_DEPTH(DEPTH)) bus ();

  stepper_move_queue #(
    .NUM_MOTORS(NM), .STEPS_PER_QUARTER(SPQ), .STEP_HALF_PERIOD(HALF),
    .SETTLE_CYCLES(SETTLE), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int face;
    int dir;
    int pulses;
    int en_len;
    int hi_min;
    int hi_max;
    int lo_min;
    int lo_max;
    int unstable;
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_err  = 0;

  // Waveform monitor: one record per enable-low window.
  int      done_cnt = 0, err_cnt = 0, stray = 0, multi_low = 0, done_late = 0;
  int      done_base, err_base, stray_base, multi_base, late_base;
  bit      in_move = 0;
  rec_t    cur;
  int      hi_run, lo_run;
  logic    prev_step = 1'b0;
  logic [NM-1:0] en_start;
  longint  cyc = 0;
  longint  end_cyc = -10;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      in_move   = 0;
      prev_step = 1'b0;
    end else begin
      if (bus.moves_done) begin
        done_cnt++;
        if (cyc != end_cyc + 1) done_late++;
      end
      if (bus.error) err_cnt++;
      if ($countones(~bus.en_pins) > 1) multi_low++;
      if (bus.en_pins != '1) begin
        if (!in_move) begin
          in_move  = 1;
          en_start = bus.en_pins;
          cur.face = -1;
          for (int i = 0; i < NM; i++) if (!bus.en_pins[i]) cur.face = i;
          cur.dir = int'(bus.dir_pin);
          cur.pulses = 0; cur.en_len = 0; cur.unstable = 0;
          cur.hi_min = 1000; cur.hi_max = 0; cur.lo_min = 1000; cur.lo_max = 0;
          hi_run = 0; lo_run = 0;
        end
        cur.en_len++;
        if (bus.en_pins !== en_start || int'(bus.dir_pin) != cur.dir) cur.unstable = 1;
        if (bus.step_pin) begin
          if (!prev_step) begin
            if (cur.pulses > 0) begin
              if (lo_run < cur.lo_min) cur.lo_min = lo_run;
              if (lo_run > cur.lo_max) cur.lo_max = lo_run;
            end
            cur.pulses++;
            hi_run = 0;
          end
          hi_run++;
        end else begin
          if (prev_step) begin
            if (hi_run < cur.hi_min) cur.hi_min = hi_run;
            if (hi_run > cur.hi_max) cur.hi_max = hi_run;
            lo_run = 0;
          end
          lo_run++;
        end
      end else begin
        if (in_move) begin
          obs_q.push_back(cur);
          end_cyc = cyc;
          in_move = 0;
        end
        if (bus.step_pin && !prev_step) stray++;
      end
      prev_step = bus.step_pin;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_move(input logic [4:0] m);
    bus.move_in    = m;
    bus.move_valid = 1'b1;
    tick();
    bus.move_valid = 1'b0;
  endtask

  // Move-level reference: what an accepted move should look like on the pins.
  task automatic model_push(input logic [4:0] m);
    rec_t r;
    int face, turn;
    face = int'(m[2:0]);
    turn = int'(m[4:3]);
    if (face >= NM) begin
      exp_err++;
    end else if (turn != 0) begin
      r.face     = face;
      r.dir      = (turn == 2) ? 0 : 1;
      r.pulses   = (turn == 3) ? 2 * SPQ : SPQ;
      r.en_len   = 2 * SETTLE + 2 * HALF * r.pulses;
      r.hi_min   = HALF; r.hi_max = HALF;
      r.lo_min   = HALF; r.lo_max = HALF;
      r.unstable = 0;
      exp_q.push_back(r);
    end
  endtask

  task automatic begin_test();
    obs_q.delete();
    exp_q.delete();
    exp_err    = 0;
    done_base  = done_cnt;
    err_base   = err_cnt;
    stray_base = stray;
    multi_base = multi_low;
    late_base  = done_late;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((bus.busy || in_move) && k < 3000) begin
      tick();
      k++;
    end
    check({tag, "_idle_in_budget"}, (k < 3000), 1);
    tick();
    tick();
  endtask

  task automatic wait_step(input string tag);
    int k = 0;
    while (!bus.step_pin && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_step_seen"}, bus.step_pin, 1);
  endtask

  task automatic compare_moves(input string tag);
    int n;
    check({tag, "_nmoves"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_m%0d_face", tag, i),   obs_q[i].face,     exp_q[i].face);
      check($sformatf("%s_m%0d_dir", tag, i),    obs_q[i].dir,      exp_q[i].dir);
      check($sformatf("%s_m%0d_pulses", tag, i), obs_q[i].pulses,   exp_q[i].pulses);
      check($sformatf("%s_m%0d_enlen", tag, i),  obs_q[i].en_len,   exp_q[i].en_len);
      check($sformatf("%s_m%0d_himin", tag, i),  obs_q[i].hi_min,   exp_q[i].hi_min);
      check($sformatf("%s_m%0d_himax", tag, i),  obs_q[i].hi_max,   exp_q[i].hi_max);
      check($sformatf("%s_m%0d_lomin", tag, i),  obs_q[i].lo_min,   exp_q[i].lo_min);
      check($sformatf("%s_m%0d_lomax", tag, i),  obs_q[i].lo_max,   exp_q[i].lo_max);
      check($sformatf("%s_m%0d_stable", tag, i), obs_q[i].unstable, 0);
    end
    check({tag, "_done_pulses"}, done_cnt - done_base, exp_q.size());
    check({tag, "_error_pulses"}, err_cnt - err_base, exp_err);
    check({tag, "_stray_steps"}, stray - stray_base, 0);
    check({tag, "_multi_enable"}, multi_low - multi_base, 0);
    check({tag, "_done_timing"}, done_late - late_base, 0);
  endtask

  initial begin
    int rise_k;
    int nb;
    logic [4:0] m;
    logic [4:0] six [6];

    bus.move_in    = '0;
    bus.move_valid = 1'b0;
    bus.flush      = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_step", bus.step_pin, 0);
    check("rst_dir", bus.dir_pin, 0);
    check("rst_en", bus.en_pins, 6'b111111);
    check("rst_ready", bus.move_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.queue_count, 0);
    check("rst_done", bus.moves_done, 0);
    check("rst_error", bus.error, 0);
    reset_n = 1'b1;
    tick(); tick();

    // Single CW quarter on face 2, with first-move latency
    begin_test();
    push_move(5'b01_010);
    model_push(5'b01_010);
    check("t1_count_after_push", bus.queue_count, 1);
    rise_k = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        check("t1_count_after_pop", bus.queue_count, 0);
        check("t1_en_in_load", bus.en_pins, 6'b111111);
      end
      if (k == 2) begin
        check("t1_en_active", bus.en_pins, 6'b111011);
        check("t1_dir", bus.dir_pin, 1);
      end
      if (bus.step_pin && rise_k == 0) rise_k = k;
    end
    check("t1_first_rise", rise_k, SETTLE + 2);
    wait_idle("t1");
    check("t1_en_released", bus.en_pins, 6'b111111);
    compare_moves("t1");

    // Half turn on face 5
    begin_test();
    push_move(5'b11_101);
    model_push(5'b11_101);
    wait_idle("t2");
    compare_moves("t2");

    // Six back-to-back pushes into depth-4 queue: the sixth is refused
    begin_test();
    six[0] = 5'b01_000; six[1] = 5'b10_001; six[2] = 5'b11_011;
    six[3] = 5'b01_100; six[4] = 5'b10_101; six[5] = 5'b01_101;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_ready_%0d", i), bus.move_ready, (i < 5) ? 1 : 0);
      if (i == 5) check("t3_count_full", bus.queue_count, DEPTH);
      push_move(six[i]);
      if (i < 5) model_push(six[i]);
    end
    wait_idle("t3");
    compare_moves("t3");

    // Out-of-range face
    begin_test();
    push_move(5'b01_110);
    model_push(5'b01_110);
    wait_idle("t4");
    compare_moves("t4");

    // Flush during the first move's step phase
    begin_test();
    push_move(5'b01_000);
    model_push(5'b01_000);
    push_move(5'b11_001);
    push_move(5'b10_010);
    wait_step("t5");
    check("t5_count_before_flush", bus.queue_count, 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t5_count_after_flush", bus.queue_count, 0);
    check("t5_busy_after_flush", bus.busy, 1);
    wait_idle("t5");
    compare_moves("t5");

    // Asynchronous reset in the middle of a step pulse
    begin_test();
    push_move(5'b01_000);
    push_move(5'b01_001);
    push_move(5'b01_011);
    wait_step("t6");
    #2 reset_n = 1'b0;
    #1;
    check("t6_step_async", bus.step_pin, 0);
    check("t6_en_async", bus.en_pins, 6'b111111);
    check("t6_count_async", bus.queue_count, 0);
    check("t6_busy_async", bus.busy, 0);
    check("t6_dir_async", bus.dir_pin, 0);
    tick(); tick(); tick();
    check("t6_no_done_in_reset", done_cnt - done_base, 0);
    reset_n = 1'b1;
    tick();
    begin_test();
    push_move(5'b10_100);
    model_push(5'b10_100);
    wait_idle("t6");
    compare_moves("t6");

    // Random bursts of up to five moves, including no-ops and bad faces
    for (int b = 0; b < 10; b++) begin
      begin_test();
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        m[2:0] = 3'($urandom_range(0, 7));
        m[4:3] = 2'($urandom_range(0, 3));
        check($sformatf("rnd%0d_ready_%0d", b, i), bus.move_ready, 1);
        push_move(m);
        model_push(m);
      end
      wait_idle($sformatf("rnd%0d", b));
      compare_moves($sformatf("rnd%0d", b));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
